mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single-port BRAM between two requesters: the CPU core (port 0, fetch and load/store traffic from the control unit) and the UART debug/loader (port 1, RxD/TxD side). It sits between both requesters and the `memory` instance, replacing the direct control-to-memory wiring.

- Default policy is round-robin, one access issued per cycle.
- The debug port can lock the memory for exclusive bursts, such as program loading; the CPU is stalled while the lock is held.
- Out-of-range and misaligned accesses are never issued to memory; the requester receives an error response instead.

## Interface
Parameters:
- `DATA_W`, 32, data width
- `ADDR_W`, 32, byte-address width
- `NUM_OF_BYTES`, 800, memory size; legal addresses are `addr < NUM_OF_BYTES`

Ports (`p` = 0 for CPU, 1 for debug):
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `req_p`  in  1  access request; held until granted
- `we_p`  in  1  1 = write, 0 = read
- `addr_p`  in  ADDR_W  byte address, must be word-aligned
- `wdata_p`  in  DATA_W  write data
- `gnt_p`  out  1  access accepted at this clock edge
- `rvalid_p`  out  1  read data or error valid, one-cycle pulse
- `rdata_p`  out  DATA_W  read data; 0 when `err_p` is set
- `err_p`  out  1  qualifies `rvalid_p` as an error response
- `dbg_lock`  in  1  debug requests exclusive ownership
- `dbg_locked`  out  1  exclusive ownership in effect
- `cpu_stall`  out  1  CPU must hold its request
- `mem_address`  out  ADDR_W  address to memory
- `mem_read_en`  out  1  read enable to memory
- `mem_write_en`  out  1  write enable to memory
- `mem_write_data`  out  DATA_W  write data to memory
- `mem_read_data`  in  DATA_W  memory read data, available one cycle after `mem_read_en`

## Operation
FSM states: SHARED, DRAIN, LOCKED.
- **SHARED**
  - If only one port requests, that port is granted.
  - If both request, the port that was not granted most recently wins.
  - `last` pointer resets to 1, so the CPU wins the first tie.
  - Transition: `dbg_lock`=1 goes to DRAIN if a read is in flight, otherwise directly to LOCKED.
- **DRAIN**
  - No grants are issued.
  - Lasts exactly one cycle, then goes to LOCKED.
- **LOCKED**
  - Only port 1 can be granted.
  - `gnt_0`=0.
  - `dbg_locked`=1.
  - `dbg_lock`=0 returns to SHARED; the next tie goes to the CPU.
- `cpu_stall` = `req_0` & ~`gnt_0`; it is also 1 in DRAIN and LOCKED whenever `req_0`=1.
- **Error check**, applied when a request is granted:
  - Error condition: `addr[1:0]`≠0 or `addr` ≥ `NUM_OF_BYTES`.
  - No memory enable is asserted.
  - The next cycle returns `rvalid_p`=1, `err_p`=1, `rdata_p`=0; this applies to writes as well.
- **Writes**
  - Complete at the grant edge.
  - No `rvalid` unless the access is an error.
- **Reads**
  - An in-flight tag register records the port.
  - The next cycle returns `rvalid_tag`=1 and `rdata_tag` = `mem_read_data`.
- `gnt` is combinational from the requests and the state. Memory outputs are combinational from the granted port's signals.
- If `req` and `dbg_lock` rise in the same cycle in SHARED, the arbitration completes that cycle and the lock takes effect the next cycle.

## Timing
- Reset values: state SHARED, `last`=1, every `gnt`/`rvalid`/`err`=0, `rdata`=0, `dbg_locked`=0, `cpu_stall`=0, memory enables 0, tag invalid.
- Read latency: grant edge N gives `rvalid` at edge N+1.
- Throughput: one access per cycle in SHARED. Back-to-back reads from alternating ports return in grant order.
- Handshake: the requester must hold `req`/`we`/`addr`/`wdata` stable until it sees `gnt` at a rising edge. It may drop `req` the cycle after.
- Reset mid-operation: the in-flight read is discarded and no `rvalid` is produced. The lock is released.

## Structure
- Shared package `cpu_pkg` holds:
  - `arb_state_t` enum (SHARED, DRAIN, LOCKED)
  - `PORT_CPU`=0, `PORT_DBG`=1
  - `ERR_RDATA`=0
- One sub-module: `arb_rr2`, a combinational two-way round-robin pick taking `req[1:0]` and `last` and returning a one-hot grant.
- The FSM, tag register, and error check live in the top module.

## Test plan
- Reset, then `req_0` read at 0x10 holding 0xDEADBEEF: `gnt_0` the same cycle; next cycle `rvalid_0`=1, `rdata_0`=0xDEADBEEF.
- Both ports request reads continuously from reset: grants alternate 0,1,0,1; each `rvalid` matches its own port; `cpu_stall` is high on the odd cycles.
- Debug writes 0x12345678 to 0x20 while the CPU reads 0x20 in the same cycle: the CPU wins first and sees the old value; the debug write follows; a subsequent CPU read returns 0x12345678.
- `dbg_lock` asserted while a CPU read is in flight: DRAIN for one cycle, the CPU `rvalid` arrives, then LOCKED. A CPU request during LOCKED keeps `cpu_stall`=1 for 8 cycles and is granted the first cycle after the lock drops.
- Read at 0x322 (misaligned) and read at 800 (out of range): no memory enable; next cycle `rvalid`=1, `err`=1, `rdata`=0.
- `reset` pulled low the cycle after a read grant: no `rvalid` and all outputs 0. After release, the CPU wins the first tie.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the memory port arbiter
package cpu_pkg;

  typedef enum logic [1:0] {
    SHARED = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam logic        PORT_CPU  = 1'b0;
  localparam logic        PORT_DBG  = 1'b1;
  localparam logic [31:0] ERR_RDATA = 32'd0;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - combinational two-way round-robin pick, one-hot grant
module arb_rr2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // last names the port granted most recently; the other one wins a tie
  assign gnt[PORT_CPU] = req[PORT_CPU] & (~req[PORT_DBG] | last);
  assign gnt[PORT_DBG] = req[PORT_DBG] & (~req[PORT_CPU] | ~last);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one BRAM port between the CPU and the debug loader
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int NUM_OF_BYTES = 800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              err_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              err_1,
  input  logic              dbg_lock,
  output logic              dbg_locked,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t        state, state_next;
  logic              last;
  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic              any_gnt, sel, sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              tag_valid, tag_port, tag_err;

  arb_rr2 u_rr (
    .req  ({req_1, req_0}),
    .last (last),
    .gnt  (pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SHARED;
      last      <= PORT_DBG;
      tag_valid <= 1'b0;
      tag_port  <= PORT_CPU;
      tag_err   <= 1'b0;
    end else begin
      state <= state_next;
      // leaving the lock always hands the next tie to the CPU
      if (state == LOCKED)
        last <= PORT_DBG;
      else if (any_gnt)
        last <= sel;
      tag_valid <= any_gnt & (~sel_we | sel_err);
      tag_port  <= sel;
      tag_err   <= sel_err;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SHARED: if (dbg_lock)
                state_next = (mem_read_en || (tag_valid && !tag_err)) ? DRAIN : LOCKED;
      DRAIN:  state_next = LOCKED;
      LOCKED: if (!dbg_lock) state_next = SHARED;
      default: state_next = SHARED;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      case (state)
        SHARED:  gnt = pick;
        LOCKED:  gnt = {req_1, 1'b0};
        default: gnt = 2'b00;
      endcase
    end
    gnt_0      = gnt[PORT_CPU];
    gnt_1      = gnt[PORT_DBG];
    dbg_locked = (state == LOCKED);
    cpu_stall  = reset & req_0 & ~gnt[PORT_CPU];
  end

  assign any_gnt   = |gnt;
  assign sel       = gnt[PORT_DBG];
  assign sel_we    = sel ? we_1 : we_0;
  assign sel_addr  = sel ? addr_1 : addr_0;
  assign sel_wdata = sel ? wdata_1 : wdata_0;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_W'(NUM_OF_BYTES));

  assign mem_address    = any_gnt ? sel_addr : '0;
  assign mem_write_data = any_gnt ? sel_wdata : '0;
  assign mem_read_en    = any_gnt & ~sel_we & ~sel_err;
  assign mem_write_en   = any_gnt & sel_we & ~sel_err;

  assign rvalid_0 = tag_valid & (tag_port == PORT_CPU);
  assign rvalid_1 = tag_valid & (tag_port == PORT_DBG);
  assign err_0    = rvalid_0 & tag_err;
  assign err_1    = rvalid_1 & tag_err;
  assign rdata_0  = (rvalid_0 && !tag_err) ? mem_read_data : DATA_W'(ERR_RDATA);
  assign rdata_1  = (rvalid_1 && !tag_err) ? mem_read_data : DATA_W'(ERR_RDATA);

endmodule
